// File: rtl/cfg_rx_pkg.sv
// rtl/cfg_rx_pkg.sv - shared widths, commit address and FSM encoding for cfg_serial_rx
// Build option: CFG_RX_PARITY_EN appends one even-parity bit to every frame.
package cfg_rx_pkg;

    localparam int WORD_W    = 23;
    localparam int ADDR_W    = 3;
    localparam int PAYLOAD_W = 20;
    localparam logic [ADDR_W-1:0] CMD_ADDR = 3'd7;

`ifdef CFG_RX_PARITY_EN
    localparam int FRAME_W = WORD_W + 1;
`else
    localparam int FRAME_W = WORD_W;
`endif

    // Bit counter saturates one above a full frame so over-long frames stay rejectable.
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
    // Cycles of synced scs_n high required before leaving WAIT_IDLE.
    localparam logic [CNT_W-1:0] WAIT_HOLD = CNT_W'(3);

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_CHECK     = 2'd3
    } rx_state_t;

endpackage

// File: rtl/pin_sync_edge.sv
// rtl/pin_sync_edge.sv - 2-FF pin synchronizer with rise/fall pulses from registered copies
// Ports: i_clk, i_rst (sync, active high), i_pin (async pin),
//        o_level (synced level), o_rise / o_fall (1-cycle edge pulses).
module pin_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
            r_s3 <= RST_VAL;
        end else begin
            r_s1 <= i_pin;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Edge pulses are decoded from flops only, so they are glitch free.
    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/cfg_serial_rx.sv
// rtl/cfg_serial_rx.sv - 3-wire serial config deserialiser feeding pin_update_slave
// Ports: i_clk, i_rst (sync, active high), i_scs_n / i_sck / i_sdin (async pins),
//        o_sdi (last accepted word), o_ssb (register write strobe), o_coe_load (commit strobe),
//        o_frame_err (reject strobe), o_busy (frame in progress).
// Build option: CFG_RX_PARITY_EN adds a trailing even-parity bit to each frame.
module cfg_serial_rx
    import cfg_rx_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_scs_n,
    input  logic              i_sck,
    input  logic              i_sdin,
    output logic [WORD_W-1:0] o_sdi,
    output logic              o_ssb,
    output logic              o_coe_load,
    output logic              o_frame_err,
    output logic              o_busy
);

    logic w_cs;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_sck_rise;
    logic w_sck_level;
    logic w_sck_fall;

    pin_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_pin   (i_scs_n),
        .o_level (w_cs),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    pin_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_pin   (i_sck),
        .o_level (w_sck_level),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    // sdin needs the same two-flop delay as sck so the sampled bit lines up with the edge.
    logic r_sd1;
    logic r_sd2;

    rx_state_t          r_state;
    logic [CNT_W-1:0]   r_count;
    logic [FRAME_W-1:0] r_shreg;
    logic               r_fall_pend;
    logic [WORD_W-1:0]  r_sdi;
    logic               r_ssb;
    logic               r_coe_load;
    logic               r_frame_err;
    logic               r_busy;

    logic [WORD_W-1:0]  w_word;
    logic               w_par_ok;
    logic               w_accept;
    logic               w_unused;

`ifdef CFG_RX_PARITY_EN
    assign w_word   = r_shreg[FRAME_W-1:1];
    assign w_par_ok = ~(^r_shreg);
`else
    assign w_word   = r_shreg;
    assign w_par_ok = 1'b1;
`endif

    assign w_accept = (r_count == CNT_FRAME) && w_par_ok;
    assign w_unused = w_sck_level ^ w_sck_fall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sd1       <= 1'b0;
            r_sd2       <= 1'b0;
            r_state     <= ST_WAIT_IDLE;
            r_count     <= '0;
            r_shreg     <= '0;
            r_fall_pend <= 1'b0;
            r_sdi       <= '0;
            r_ssb       <= 1'b0;
            r_coe_load  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sd1       <= i_sdin;
            r_sd2       <= r_sd1;
            r_ssb       <= 1'b0;
            r_coe_load  <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_state)
                ST_WAIT_IDLE: begin
                    // The synchronizer resets to "deselected", so a pin held low across
                    // reset still reads high for two cycles; the counter here waits out
                    // that artefact before trusting the level.
                    r_busy <= 1'b0;
                    if (!w_cs) begin
                        r_count <= '0;
                    end else if (r_count == WAIT_HOLD) begin
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (w_cs_fall || r_fall_pend) begin
                        r_state     <= ST_SHIFT;
                        r_count     <= '0;
                        r_shreg     <= '0;
                        r_fall_pend <= 1'b0;
                        r_busy      <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    r_busy <= 1'b1;
                    // Frame end wins over a coincident sck rise: that bit is dropped.
                    if (w_cs_rise) begin
                        r_state <= ST_CHECK;
                    end else if (w_sck_rise) begin
                        r_shreg <= {r_shreg[FRAME_W-2:0], r_sd2};
                        if (r_count != CNT_MAX) begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end

                ST_CHECK: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_fall_pend <= w_cs_fall;
                    if (!w_accept) begin
                        r_frame_err <= 1'b1;
                    end else if (w_word[ADDR_W-1:0] == CMD_ADDR) begin
                        r_coe_load <= 1'b1;
                    end else begin
                        r_sdi <= w_word;
                        r_ssb <= 1'b1;
                    end
                end

                default: r_state <= ST_WAIT_IDLE;
            endcase
        end
    end

    assign o_sdi       = r_sdi;
    assign o_ssb       = r_ssb;
    assign o_coe_load  = r_coe_load;
    assign o_frame_err = r_frame_err;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_cfg_serial_rx.sv
// tb/tb_cfg_serial_rx.sv - scoreboard bench for cfg_serial_rx with directed frames
module tb_cfg_serial_rx;

`ifdef CFG_RX_PARITY_EN
    localparam int FW = 24;
`else
    localparam int FW = 23;
`endif

    localparam logic [1:0] K_SSB = 2'd1;
    localparam logic [1:0] K_COE = 2'd2;
    localparam logic [1:0] K_ERR = 2'd3;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        scs_n = 1'b1;
    logic        sck   = 1'b0;
    logic        sdin  = 1'b0;
    logic [22:0] o_sdi;
    logic        o_ssb;
    logic        o_coe_load;
    logic        o_frame_err;
    logic        o_busy;

    cfg_serial_rx dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_scs_n     (scs_n),
        .i_sck       (sck),
        .i_sdin      (sdin),
        .o_sdi       (o_sdi),
        .o_ssb       (o_ssb),
        .o_coe_load  (o_coe_load),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [22:0] sdi;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [22:0] exp_sdi = '0;
    logic [1:0]  mon_k;
    exp_t        mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest expected response.
    always @(negedge clk) begin
        if (!rst && (o_ssb || o_coe_load || o_frame_err)) begin
            mon_k = o_ssb ? K_SSB : (o_coe_load ? K_COE : K_ERR);
            chk("strobe_onehot", 32'($countones({o_ssb, o_coe_load, o_frame_err})), 32'd1);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=kind%0d required=none", mon_k);
            end else begin
                mon_e = q.pop_front();
                chk("strobe_kind", 32'(mon_k), 32'(mon_e.kind));
                chk("strobe_sdi", 32'(o_sdi), 32'(mon_e.sdi));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            sdin = bits[i];
            clk_n(4);
            sck = 1'b1;
            clk_n(4);
            sck = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n, input int gap);
        scs_n = 1'b0;
        clk_n(4);
        shift_bits(bits, n - 1, 0);
        clk_n(4);
        scs_n = 1'b1;
        clk_n(gap);
    endtask

    function automatic logic [31:0] frame_of(input logic [22:0] w);
`ifdef CFG_RX_PARITY_EN
        return {8'd0, w, ^w};
`else
        return {9'd0, w};
`endif
    endfunction

    task automatic expect_ssb(input logic [22:0] w);
        q.push_back({K_SSB, w});
        exp_sdi = w;
    endtask

    task automatic expect_held(input logic [1:0] k);
        q.push_back({k, exp_sdi});
    endtask

    initial begin
        clk_n(3);
        chk("rst_sdi", 32'(o_sdi), 32'd0);
        chk("rst_strobes", {29'd0, o_ssb, o_coe_load, o_frame_err}, 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;
        clk_n(10);

        // 1: addr 1 frame, with latency and busy checks done inline
        expect_ssb(23'h2ABCD9);
        scs_n = 1'b0;
        clk_n(4);
        shift_bits(frame_of(23'h2ABCD9), FW - 1, 0);
        clk_n(4);
        chk("busy_shift", 32'(o_busy), 32'd1);
        scs_n = 1'b1;
        clk_n(3);
        chk("ssb_early", 32'(o_ssb), 32'd0);
        clk_n(1);
        chk("ssb_edge4", 32'(o_ssb), 32'd1);
        chk("coe_edge4", 32'(o_coe_load), 32'd0);
        clk_n(1);
        chk("ssb_one_cycle", 32'(o_ssb), 32'd0);
        clk_n(10);
        chk("busy_idle", 32'(o_busy), 32'd0);

        // 2: commit frame, payload 0x12345 addr 7 -> 0x091A2F
        expect_held(K_COE);
        send_bits(frame_of(23'h091A2F), FW, 12);
        chk("coe_sdi_held", 32'(o_sdi), 32'h2ABCD9);

        // 3: one bit short, one bit long
        expect_held(K_ERR);
        send_bits(frame_of(23'h2ABCD9) >> 1, FW - 1, 12);
        expect_held(K_ERR);
        send_bits(frame_of(23'h2ABCD9) << 1, FW + 1, 12);
        chk("err_sdi_held", 32'(o_sdi), 32'h2ABCD9);

        // 4: reset after 11 bits; the tail of that frame must stay silent
        scs_n = 1'b0;
        clk_n(4);
        shift_bits(frame_of(23'h2ABCD9), FW - 1, FW - 11);
        rst = 1'b1;
        clk_n(1);
        chk("midrst_sdi", 32'(o_sdi), 32'd0);
        chk("midrst_strobes", {29'd0, o_ssb, o_coe_load, o_frame_err}, 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;
        exp_sdi = '0;
        shift_bits(frame_of(23'h2ABCD9), FW - 12, 0);
        clk_n(4);
        scs_n = 1'b1;
        clk_n(12);
        chk("midrst_no_accept", 32'(o_sdi), 32'd0);
        expect_ssb(23'h155552);
        send_bits(frame_of(23'h155552), FW, 12);

        // 5: back-to-back frames, scs_n high for one bit period
        expect_ssb(23'h000003);
        send_bits(frame_of(23'h000003), FW, 8);
        expect_ssb(23'h7FFFFC);
        send_bits(frame_of(23'h7FFFFC), FW, 12);
        chk("b2b_sdi", 32'(o_sdi), 32'h7FFFFC);

`ifdef CFG_RX_PARITY_EN
        // 6: 0x2ABCD9 has 13 ones, so even parity bit is 1
        expect_ssb(23'h2ABCD9);
        send_bits(32'h5579B3, 24, 12);
        expect_held(K_ERR);
        send_bits(32'h5579B2, 24, 12);
        chk("par_sdi", 32'(o_sdi), 32'h2ABCD9);
`endif

        clk_n(20);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
